// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised asynchronous serial transmitter.
// Sends one word per frame: start bit, DATA_WIDTH data bits (MSB or LSB first),
// optional even/odd parity bit, then 1 or 2 stop bits. Bit period is CLKS_PER_BIT clocks.
//
// Ports:
//   CLK       system clock, rising edge
//   RST       asynchronous active-high reset
//   TX_VALID  TX_DATA holds a word to send
//   TX_DATA   word to send, latched at the accept edge
//   TX_READY  block can accept a word this cycle (IDLE only)
//   TXD       serial line, idle/mark = 1
//   TX_BUSY   frame in progress
//   TX_DONE   one-cycle pulse in the first IDLE cycle after the last stop bit
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_VALID,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_READY,
  output logic                  TXD,
  output logic                  TX_BUSY,
  output logic                  TX_DONE
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned NStop = (STOP_BITS == 2) ? 2 : 1;

  localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0]  LastStop = BitW'(NStop - 1);
  localparam logic             ParEn    = (PARITY == 1) || (PARITY == 2);
  localparam logic             OddPar   = (PARITY == 2);
  localparam logic             MsbFirst = (MSB_FIRST != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  txd_d, busy_d, ready_d, done_d;
  logic                  baud_end;

  assign baud_end = (baud_q == BaudMax);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    txd_d   = 1'b1;

    unique case (state_q)
      StIdle: begin
        // TX_READY is 1 throughout IDLE, so TX_VALID alone means accept
        if (TX_VALID) begin
          state_d = StStart;
          shift_d = TX_DATA;
          par_d   = (^TX_DATA) ^ OddPar;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (baud_end) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == LastBit) begin
            bit_d   = '0;
            state_d = ParEn ? StParity : StStop;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = MsbFirst ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[DATA_WIDTH-1:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StParity: begin
        if (baud_end) begin
          state_d = StStop;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        // bit counter is reused to count stop bits
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == LastStop) begin
            bit_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are registered: drive the line value of the state being entered.
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = MsbFirst ? shift_d[DATA_WIDTH-1] : shift_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase

    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      TXD      <= 1'b1;
      TX_BUSY  <= 1'b0;
      TX_READY <= 1'b1;
      TX_DONE  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      TXD      <= txd_d;
      TX_BUSY  <= busy_d;
      TX_READY <= ready_d;
      TX_DONE  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame. Three instances cover the parameter sets:
//   a: DATA_WIDTH 8, CLKS_PER_BIT 4, even parity, 1 stop, MSB first
//   b: DATA_WIDTH 8, CLKS_PER_BIT 4, odd parity, 2 stop, LSB first
//   c: DATA_WIDTH 5, CLKS_PER_BIT 2, no parity, 1 stop, MSB first
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic       va, vb, vc;
  logic [7:0] da, db;
  logic [4:0] dc;
  logic       ra, rb, rc;
  logic       txa, txb, txc;
  logic       ba, bb, bc;
  logic       dna, dnb, dnc;

  int unsigned checks;
  int unsigned errors;

  uart_tx_frame #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(1)
  ) dut_a (
    .CLK(clk), .RST(rst), .TX_VALID(va), .TX_DATA(da), .TX_READY(ra),
    .TXD(txa), .TX_BUSY(ba), .TX_DONE(dna)
  );

  uart_tx_frame #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(0)
  ) dut_b (
    .CLK(clk), .RST(rst), .TX_VALID(vb), .TX_DATA(db), .TX_READY(rb),
    .TXD(txb), .TX_BUSY(bb), .TX_DONE(dnb)
  );

  uart_tx_frame #(
    .DATA_WIDTH(5), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1)
  ) dut_c (
    .CLK(clk), .RST(rst), .TX_VALID(vc), .TX_DATA(dc), .TX_READY(rc),
    .TXD(txc), .TX_BUSY(bc), .TX_DONE(dnc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_a txd/busy/ready/done=%b expected 1010", {txa, ba, ra, dna});
    end
    checks++;
    if ({txb, bb, rb, dnb} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_b txd/busy/ready/done=%b expected 1010", {txb, bb, rb, dnb});
    end
    checks++;
    if ({txc, bc, rc, dnc} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_c txd/busy/ready/done=%b expected 1010", {txc, bc, rc, dnc});
    end
  endtask

  // 8'hA5, even parity 0: 0 10100101 0 1, 4 clocks per bit, F = 44
  task automatic test_even_parity();
    logic [10:0] f;
    f = 11'b01010010101;
    @(negedge clk);
    va = 1'b1;
    da = 8'hA5;
    @(negedge clk);
    va = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      checks++;
      if ({txa, ba, ra, dna} !== {f[10 - (c - 1) / 4], 3'b100}) begin
        errors++;
        $display("FAIL even_frame cycle %0d txd/busy/ready/done=%b expected %b", c,
                 {txa, ba, ra, dna}, {f[10 - (c - 1) / 4], 3'b100});
      end
      @(negedge clk);
    end
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1011) begin
      errors++;
      $display("FAIL even_done cycle 45 txd/busy/ready/done=%b expected 1011",
               {txa, ba, ra, dna});
    end
    @(negedge clk);
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1010) begin
      errors++;
      $display("FAIL even_after txd/busy/ready/done=%b expected 1010", {txa, ba, ra, dna});
    end
  endtask

  // 8'h01 LSB first, odd parity 0, two stop bits: 0 10000000 0 1 1, F = 48
  task automatic test_odd_lsb_two_stop();
    logic [11:0] f;
    f = 12'b010000000011;
    @(negedge clk);
    vb = 1'b1;
    db = 8'h01;
    @(negedge clk);
    vb = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      checks++;
      if ({txb, bb, rb, dnb} !== {f[11 - (c - 1) / 4], 3'b100}) begin
        errors++;
        $display("FAIL odd_frame cycle %0d txd/busy/ready/done=%b expected %b", c,
                 {txb, bb, rb, dnb}, {f[11 - (c - 1) / 4], 3'b100});
      end
      @(negedge clk);
    end
    checks++;
    if ({txb, bb, rb, dnb} !== 4'b1011) begin
      errors++;
      $display("FAIL odd_done cycle 49 txd/busy/ready/done=%b expected 1011",
               {txb, bb, rb, dnb});
    end
  endtask

  // TX_VALID held: 3C then C3, one idle mark cycle (the TX_DONE cycle) in between
  task automatic test_back_to_back();
    logic [10:0] f1, f2;
    logic [3:0]  exp;
    int          dones;
    f1 = 11'b00011110001;
    f2 = 11'b01100001101;
    dones = 0;
    @(negedge clk);
    va = 1'b1;
    da = 8'h3C;
    @(negedge clk);
    da = 8'hC3;
    for (int c = 1; c <= 90; c++) begin
      if (c <= 44)      exp = {f1[10 - (c - 1) / 4], 3'b100};
      else if (c == 45) exp = 4'b1011;
      else if (c <= 89) exp = {f2[10 - (c - 46) / 4], 3'b100};
      else              exp = 4'b1011;
      if (dna === 1'b1) dones++;
      checks++;
      if ({txa, ba, ra, dna} !== exp) begin
        errors++;
        $display("FAIL b2b cycle %0d txd/busy/ready/done=%b expected %b", c,
                 {txa, ba, ra, dna}, exp);
      end
      if (c == 90) va = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_idle txd/busy/ready/done=%b expected 1010", {txa, ba, ra, dna});
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d expected 2", dones);
    end
  endtask

  // TX_DATA and TX_VALID wiggled mid-frame: 8'h96 = 0 10010110 0 1
  task automatic test_busy_ignore();
    logic [10:0] f;
    f = 11'b01001011001;
    @(negedge clk);
    va = 1'b1;
    da = 8'h96;
    @(negedge clk);
    for (int c = 1; c <= 44; c++) begin
      checks++;
      if ({txa, ba, ra, dna} !== {f[10 - (c - 1) / 4], 3'b100}) begin
        errors++;
        $display("FAIL ignore cycle %0d txd/busy/ready/done=%b expected %b", c,
                 {txa, ba, ra, dna}, {f[10 - (c - 1) / 4], 3'b100});
      end
      va = ~va;
      da = 8'(c * 37);
      @(negedge clk);
    end
    va = 1'b0;
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1011) begin
      errors++;
      $display("FAIL ignore_done txd/busy/ready/done=%b expected 1011", {txa, ba, ra, dna});
    end
    @(negedge clk);
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1010) begin
      errors++;
      $display("FAIL ignore_no_accept txd/busy/ready/done=%b expected 1010",
               {txa, ba, ra, dna});
    end
  endtask

  // Reset between edges during data bit 1, then a clean 8'h5A frame: 0 01011010 0 1
  task automatic test_reset_mid_frame();
    logic [10:0] f;
    f = 11'b00101101001;
    @(negedge clk);
    va = 1'b1;
    da = 8'hA5;
    @(negedge clk);
    va = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if ({txa, ba} !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset txd/busy=%b expected 01", {txa, ba});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1010) begin
      errors++;
      $display("FAIL async_reset txd/busy/ready/done=%b expected 1010", {txa, ba, ra, dna});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if ({txa, ba, ra, dna} !== 4'b1010) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d txd/busy/ready/done=%b expected 1010", c,
                 {txa, ba, ra, dna});
      end
      @(negedge clk);
    end
    va = 1'b1;
    da = 8'h5A;
    @(negedge clk);
    va = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      checks++;
      if ({txa, ba, ra, dna} !== {f[10 - (c - 1) / 4], 3'b100}) begin
        errors++;
        $display("FAIL after_reset_frame cycle %0d txd/busy/ready/done=%b expected %b", c,
                 {txa, ba, ra, dna}, {f[10 - (c - 1) / 4], 3'b100});
      end
      @(negedge clk);
    end
    checks++;
    if ({txa, ba, ra, dna} !== 4'b1011) begin
      errors++;
      $display("FAIL after_reset_done txd/busy/ready/done=%b expected 1011",
               {txa, ba, ra, dna});
    end
  endtask

  // 5-bit word 5'h1F, no parity, 2 clocks per bit: 0 11111 1, F = 14
  task automatic test_narrow_no_parity();
    logic [6:0] f;
    f = 7'b0111111;
    @(negedge clk);
    vc = 1'b1;
    dc = 5'h1F;
    @(negedge clk);
    vc = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if ({txc, bc, rc, dnc} !== {f[6 - (c - 1) / 2], 3'b100}) begin
        errors++;
        $display("FAIL narrow_frame cycle %0d txd/busy/ready/done=%b expected %b", c,
                 {txc, bc, rc, dnc}, {f[6 - (c - 1) / 2], 3'b100});
      end
      @(negedge clk);
    end
    checks++;
    if ({txc, bc, rc, dnc} !== 4'b1011) begin
      errors++;
      $display("FAIL narrow_done txd/busy/ready/done=%b expected 1011", {txc, bc, rc, dnc});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    va = 1'b0;
    vb = 1'b0;
    vc = 1'b0;
    da = '0;
    db = '0;
    dc = '0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_even_parity();
    test_odd_lsb_two_stop();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_narrow_no_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
